alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 66 ++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters; ports: clk/rst_n, req_* (valid/ready/ctrl/a/b/shamt per requester), alu_* (drive shared ALU, alu_out back), resp_* (valid/ready/data/zero per requester)
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [3:0]    req_ctrl0,
  input  logic [3:0]    req_ctrl1,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  input  logic [4:0]    req_shamt0,
  input  logic [4:0]    req_shamt1,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_shamt,
  input  logic [DW-1:0] alu_out,
  output logic [1:0]    resp_valid,
  input  logic [1:0]    resp_ready,
  output logic [DW-1:0] resp_data0,
  output logic [DW-1:0] resp_data1,
  output logic [1:0]    resp_zero
);
  logic [1:0]    elig, gnt;
  logic          last_gnt_q, last_gnt_d;
  logic [1:0]    resp_valid_q, resp_valid_d, resp_zero_q, resp_zero_d;
  logic [DW-1:0] resp_data0_q, resp_data0_d, resp_data1_q, resp_data1_d;
  always_comb begin
    elig         = req_valid & (~resp_valid_q | resp_ready);
    gnt          = !rst_n ? 2'b00 : (&elig) ? (last_gnt_q ? 2'b01 : 2'b10) : elig;
    req_ready    = gnt;
    alu_ctrl     = gnt[0] ? req_ctrl0  : gnt[1] ? req_ctrl1  : 4'b0000;
    alu_a        = gnt[0] ? req_a0     : gnt[1] ? req_a1     : '0;
    alu_b        = gnt[0] ? req_b0     : gnt[1] ? req_b1     : '0;
    alu_shamt    = gnt[0] ? req_shamt0 : gnt[1] ? req_shamt1 : 5'd0;
    last_gnt_d   = (|gnt) ? gnt[1] : last_gnt_q;
    resp_valid_d = gnt | (resp_valid_q & ~resp_ready);
    resp_data0_d = gnt[0] ? alu_out : resp_data0_q;
    resp_data1_d = gnt[1] ? alu_out : resp_data1_q;
    resp_zero_d  = {gnt[1] ? (alu_out == '0) : resp_zero_q[1],
                    gnt[0] ? (alu_out == '0) : resp_zero_q[0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q   <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_zero_q  <= 2'b00;
      resp_data0_q <= '0;
      resp_data1_q <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_zero_q  <= resp_zero_d;
      resp_data0_q <= resp_data0_d;
      resp_data1_q <= resp_data1_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_zero  = resp_zero_q;
  assign resp_data0 = resp_data0_q;
  assign resp_data1 = resp_data1_q;
endmodule
